// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall / flush / redirect generation for the 5-stage RV32IM pipeline.
// Sources, highest priority first: pending data-memory access, multi-cycle divide,
// resolved jump from EX, decode load-use hazard. Only the DIV and MEMW waits hold
// state; every other decision is made fresh each cycle from the inputs.
module pipe_ctrl #(
    parameter int XLEN    = 32,
    parameter int DIV_LAT = 33
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            loaduse_hazard_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            div_start_i,
    input  logic            mem_req_i,
    input  logic            mem_ack_i,
    output logic            stall_pc_o,
    output logic            stall_if_o,
    output logic            stall_id_o,
    output logic            stall_ex_o,
    output logic            stall_mem_o,
    output logic            flush_if_o,
    output logic            flush_id_o,
    output logic            flush_ex_o,
    output logic            flush_mem_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o,
    output logic [1:0]      state_o,
    output logic [31:0]     stall_cnt_o
);

    localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_MEMW = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] div_cnt_reg, div_cnt_next;
    logic [31:0]      stall_cnt_reg;

    // Which single action wins this cycle; at most one is set.
    logic act_mem, act_div, act_jump, act_lu;

    // Arbitrate the hazard sources and pick the next wait state.
    always_comb begin
        act_mem      = 1'b0;
        act_div      = 1'b0;
        act_jump     = 1'b0;
        act_lu       = 1'b0;
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        case (state_reg)
            ST_RUN, ST_MEMW: begin
                // In MEMW the request is known to be outstanding, so only the ack matters.
                if ((state_reg == ST_RUN && mem_req_i && !mem_ack_i) ||
                    (state_reg == ST_MEMW && !mem_ack_i)) begin
                    act_mem    = 1'b1;
                    state_next = ST_MEMW;
                end else if (div_start_i) begin
                    act_div      = 1'b1;
                    div_cnt_next = DIV_LOAD;
                    state_next   = ST_DIV;
                end else begin
                    state_next = ST_RUN;
                    if (jump_i) begin
                        act_jump = 1'b1;
                    end else if (loaduse_hazard_i) begin
                        act_lu = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                if (div_cnt_reg != '0) begin
                    act_div      = 1'b1;
                    div_cnt_next = div_cnt_reg - CNT_ONE;
                end else begin
                    // Release: MEM holds a bubble and a div is never a jump, so only
                    // the load-use hazard can still act here.
                    act_lu     = loaduse_hazard_i;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // While reset is asserted every control output is forced inactive.
    assign stall_pc_o  = rst_ni & (act_mem | act_div | act_lu);
    assign stall_if_o  = rst_ni & (act_mem | act_div | act_lu);
    assign stall_id_o  = rst_ni & (act_mem | act_div);
    assign stall_ex_o  = rst_ni & act_mem;
    assign stall_mem_o = rst_ni & act_mem;
    assign flush_if_o  = rst_ni & act_jump;
    assign flush_id_o  = rst_ni & (act_jump | act_lu);
    assign flush_ex_o  = rst_ni & act_div;
    assign flush_mem_o = rst_ni & act_mem;
    assign redirect_o  = rst_ni & act_jump;
    assign busy_o      = rst_ni & (state_reg != ST_RUN);
    assign state_o     = rst_ni ? state_reg : ST_RUN;
    assign stall_cnt_o = stall_cnt_reg;

    // Redirect target is zero whenever no redirect is taken.
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_redirect_pc
            assign redirect_pc_o[gi] = jump_addr_i[gi] & redirect_o;
        end
    endgenerate

    // Wait-state FSM, divider countdown and stall-cycle counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= ST_RUN;
            div_cnt_reg   <= '0;
            stall_cnt_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            if (stall_pc_o) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus for pipe_ctrl with a source-priority model that is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_pipe_ctrl;

    localparam int XLEN    = 32;
    localparam int DIV_LAT = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            loaduse_hazard_i, jump_i, div_start_i, mem_req_i, mem_ack_i;
    logic [XLEN-1:0] jump_addr_i;
    logic            stall_pc_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic            flush_if_o, flush_id_o, flush_ex_o, flush_mem_o, redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            busy_o;
    logic [1:0]      state_o;
    logic [31:0]     stall_cnt_o;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.XLEN(XLEN), .DIV_LAT(DIV_LAT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .loaduse_hazard_i(loaduse_hazard_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .div_start_i(div_start_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .stall_pc_o(stall_pc_o), .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
        .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o),
        .flush_if_o(flush_if_o), .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
        .flush_mem_o(flush_mem_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .busy_o(busy_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
    );

    // {stall pc,if,id,ex,mem, flush if,id,ex,mem, redirect}
    logic [9:0] outs;
    assign outs = {stall_pc_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
                   flush_if_o, flush_id_o, flush_ex_o, flush_mem_o, redirect_o};

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int S_NONE = 0, S_LU = 1, S_JMP = 2, S_DIV = 3, S_MEM = 4;

    int          m_mode  = 0;   // 0 running, 1 waiting on divider, 2 waiting on memory
    int          m_left  = 0;   // divider stall cycles still owed after the first
    logic [31:0] m_cnt   = 0;   // stall cycles seen since reset
    logic [31:0] cnt_ofs = 0;   // preload applied by the wrap test
    bit          m_valid = 0;

    function automatic int run_pick();
        if (div_start_i)      return S_DIV;
        if (jump_i)           return S_JMP;
        if (loaduse_hazard_i) return S_LU;
        return S_NONE;
    endfunction

    function automatic int cur_src();
        if (!rst_ni) return S_NONE;
        if (m_mode == 1) return (m_left > 0) ? S_DIV : (loaduse_hazard_i ? S_LU : S_NONE);
        if (m_mode == 2) return !mem_ack_i ? S_MEM : run_pick();
        if (mem_req_i && !mem_ack_i) return S_MEM;
        return run_pick();
    endfunction

    function automatic logic [9:0] src_outs(input int s);
        case (s)
            S_LU:    return 10'b11000_01000;
            S_JMP:   return 10'b00000_11001;
            S_DIV:   return 10'b11100_00100;
            S_MEM:   return 10'b11111_00010;
            default: return 10'b00000_00000;
        endcase
    endfunction

    // Advance the model on each rising edge.
    int upd_s;
    initial forever begin
        @(posedge clk_i);
        upd_s = cur_src();
        if (!rst_ni) begin
            m_mode = 0; m_left = 0; m_cnt = 0; m_valid = 1;
        end else begin
            if (upd_s == S_MEM || upd_s == S_DIV || upd_s == S_LU) m_cnt = m_cnt + 32'd1;
            if (m_mode == 1) begin
                if (m_left > 0) m_left = m_left - 1;
                else            m_mode = 0;
            end else if (upd_s == S_MEM) begin
                m_mode = 2;
            end else if (upd_s == S_DIV) begin
                m_mode = 1; m_left = DIV_LAT - 1;
            end else begin
                m_mode = 0;
            end
        end
    end

    // Compare every cycle, mid-way between drive (falling edge) and next rising edge.
    int cmp_s;
    initial forever begin
        @(negedge clk_i);
        #2;
        if (m_valid) begin
            cmp_s = cur_src();
            check("model_ctrl", {22'd0, outs}, {22'd0, src_outs(cmp_s)});
            check("model_rpc", redirect_pc_o, (cmp_s == S_JMP) ? jump_addr_i : 32'd0);
            check("model_busy", {31'd0, busy_o}, {31'd0, (rst_ni && m_mode != 0)});
            check("model_state", {30'd0, state_o}, rst_ni ? 32'(m_mode) : 32'd0);
            check("model_cnt", stall_cnt_o, m_cnt + cnt_ofs);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic r, input logic l, input logic j, input logic [31:0] a,
                         input logic d, input logic q, input logic k);
        @(negedge clk_i);
        rst_ni = r; loaduse_hazard_i = l; jump_i = j; jump_addr_i = a;
        div_start_i = d; mem_req_i = q; mem_ack_i = k;
    endtask

    task automatic idle();
        drive(1, 0, 0, 32'd0, 0, 0, 0);
    endtask

    initial begin
        rst_ni = 0; loaduse_hazard_i = 1; jump_i = 1; jump_addr_i = 32'hFFFF_FFFF;
        div_start_i = 1; mem_req_i = 1; mem_ack_i = 1;

        // Reset held with every input high
        repeat (3) drive(0, 1, 1, 32'hFFFF_FFFF, 1, 1, 1);
        #3;
        check("rst_outs", {22'd0, outs}, 32'd0);
        check("rst_rpc", redirect_pc_o, 32'd0);
        check("rst_state", {30'd0, state_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);

        // Release with only the load-use hazard
        drive(1, 1, 0, 32'd0, 0, 0, 0); #3;
        check("rel_lu", {29'd0, stall_pc_o, stall_if_o, flush_id_o}, 32'd7);
        idle(); #3;
        check("rel_cnt", stall_cnt_o, 32'd1);
        idle();

        // Divide: DIV_LAT stall cycles, then a release cycle with the request still up
        repeat (DIV_LAT) begin
            drive(1, 0, 0, 32'd0, 1, 0, 0); #3;
            check("div_stall", {30'd0, stall_pc_o, flush_ex_o}, 32'd3);
        end
        drive(1, 0, 0, 32'd0, 1, 0, 0); #3;
        check("div_release", {31'd0, stall_pc_o}, 32'd0);
        idle(); #3;
        check("div_state", {30'd0, state_o}, 32'd0);
        check("div_cnt", stall_cnt_o, 32'd5);

        // Reset in the middle of a divide
        repeat (2) drive(1, 0, 0, 32'd0, 1, 0, 0);
        drive(0, 0, 0, 32'd0, 1, 0, 0); #3;
        check("divrst_outs", {22'd0, outs}, 32'd0);
        idle(); #3;
        check("divrst_state", {30'd0, state_o}, 32'd0);
        check("divrst_cnt", stall_cnt_o, 32'd0);

        // Jump suppresses load-use
        drive(1, 1, 1, 32'h0000_0100, 0, 0, 0); #3;
        check("jmp_rpc", redirect_pc_o, 32'h0000_0100);
        check("jmp_ctrl", {28'd0, flush_if_o, flush_id_o, redirect_o, stall_pc_o}, 32'hE);

        // Memory wait of 3 cycles with a jump held in EX
        repeat (3) begin
            drive(1, 0, 1, 32'h0000_0200, 0, 1, 0); #3;
            check("memj_wait", {30'd0, stall_pc_o, redirect_o}, 32'd2);
        end
        drive(1, 0, 1, 32'h0000_0200, 0, 1, 1); #3;
        check("memj_ack", {30'd0, redirect_o, stall_pc_o}, 32'd2);
        check("memj_rpc", redirect_pc_o, 32'h0000_0200);
        idle(); #3;
        check("memj_cnt", stall_cnt_o, 32'd3);

        // Memory wait released straight into a divide: no gap cycle
        repeat (2) drive(1, 0, 0, 32'd0, 0, 1, 0);
        drive(1, 0, 0, 32'd0, 1, 1, 1); #3;
        check("memdiv_hand", {29'd0, stall_pc_o, state_o}, 32'd6);
        repeat (DIV_LAT - 1) begin
            drive(1, 0, 0, 32'd0, 1, 0, 0); #3;
            check("memdiv_stall", {31'd0, stall_pc_o}, 32'd1);
        end
        idle(); #3;
        check("memdiv_release", {31'd0, stall_pc_o}, 32'd0);
        idle(); #3;
        check("memdiv_cnt", stall_cnt_o, 32'd9);

        // Same-cycle ack never stalls
        drive(1, 0, 0, 32'd0, 0, 1, 1); #3;
        check("ack0_stall", {31'd0, stall_pc_o}, 32'd0);
        idle(); #3;
        check("ack0_state", {30'd0, state_o}, 32'd0);

        // Divide wins over jump; release cycle sees load-use but ignores mem/jump
        drive(1, 0, 1, 32'h0000_0300, 1, 0, 0); #3;
        check("divjmp", {30'd0, stall_pc_o, redirect_o}, 32'd2);
        repeat (DIV_LAT - 1) drive(1, 0, 0, 32'd0, 1, 0, 0);
        drive(1, 1, 1, 32'h0000_0300, 0, 1, 0); #3;
        check("divrel_lu", {27'd0, stall_pc_o, flush_id_o, stall_mem_o, redirect_o, busy_o},
              32'b11001);
        idle(); #3;
        check("divrel_cnt", stall_cnt_o, 32'd14);

        // Counter wrap
        idle();
        force dut.stall_cnt_reg = 32'hFFFF_FFFF;
        cnt_ofs = 32'hFFFF_FFFF - m_cnt;
        #1;
        release dut.stall_cnt_reg;
        drive(1, 1, 0, 32'd0, 0, 0, 0);
        idle(); #3;
        check("wrap_cnt", stall_cnt_o, 32'd0);
        repeat (2) idle();

        #3;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
